sipo_deframer: RTL and testbench

Serial-to-parallel deframer that sits directly downstream of the `siso` shift register and consumes its `s_out` bit stream. It collects `WIDTH` qualified serial bits, LSB first, into one parallel word. It presents that word on a valid/ready handshake to the next stage. A one-word output holding register lets assembly of the next word continue while the consumer stalls; loss is flagged by a sticky overrun bit.

---
 rtl/ser_pkg.sv | 13 +
 rtl/sipo_deframer_if.sv | 24 ++
 rtl/sipo_shifter.sv | 54 +++++
 rtl/sipo_deframer.sv | 72 +++++++
 tb/tb_sipo_deframer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ser_pkg.sv
// Shared serial-link definitions used by the siso/piso/sipo blocks and benches.
package ser_pkg;

    // Default parallel word width for the serial link family.
    localparam int unsigned WIDTH_DEF = 4;

    // Output holding register occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/sipo_deframer_if.sv
// Serial-in / parallel-out handshake bundle for sipo_deframer.
interface sipo_deframer_if #(
    parameter int unsigned WIDTH = ser_pkg::WIDTH_DEF
);
    logic             s_in;
    logic             s_valid;
    logic             s_clr;
    logic [WIDTH-1:0] p_out;
    logic             p_valid;
    logic             p_ready;
    logic             overrun;

    // Producer of serial bits and consumer of parallel words.
    modport master (
        output s_in, s_valid, s_clr, p_ready,
        input  p_out, p_valid, overrun
    );

    // The deframer itself.
    modport slave (
        input  s_in, s_valid, s_clr, p_ready,
        output p_out, p_valid, overrun
    );
endinterface

// File: rtl/sipo_shifter.sv
// Bit counter plus assembly register: collects WIDTH serial bits, LSB first.
// word/word_done are combinational so the top can capture the finished word
// on the same edge that samples its last bit.
module sipo_shifter
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             s_clr,
    output logic [WIDTH-1:0] word,
    output logic             word_done
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] asm_q, asm_d;

    // Next-state: realign has priority, otherwise place the bit and advance.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        asm_d     = asm_q;
        word_done = 1'b0;
        if (s_clr) begin
            bit_cnt_d = '0;
            asm_d     = '0;
        end else if (s_valid) begin
            asm_d[bit_cnt_q] = s_in;
            if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                bit_cnt_d = '0;
                word_done = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    // Word including the bit being accepted this edge.
    assign word = asm_d;

    // Counter and assembly register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q <= '0;
            asm_q     <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            asm_q     <= asm_d;
        end
    end
endmodule

// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: assembles words from a qualified bit stream and
// offers them through a one-word holding register with a sticky overrun flag.
module sipo_deframer
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    sipo_deframer_if.slave  bus
);
    out_state_t       state_q, state_d;
    logic [WIDTH-1:0] p_out_q, p_out_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             handshake;

    sipo_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .s_in      (bus.s_in),
        .s_valid   (bus.s_valid),
        .s_clr     (bus.s_clr),
        .word      (word),
        .word_done (word_done)
    );

    assign handshake = (state_q == FULL) && bus.p_ready;

    // Output FSM: load on completion, drain on handshake, drop and flag when full.
    always_comb begin
        state_d   = state_q;
        p_out_d   = p_out_q;
        overrun_d = overrun_q;
        case (state_q)
            EMPTY: begin
                if (word_done) begin
                    state_d = FULL;
                    p_out_d = word;
                end
            end
            FULL: begin
                if (word_done) begin
                    if (handshake) p_out_d   = word;
                    else           overrun_d = 1'b1;
                end else if (handshake) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (bus.s_clr) overrun_d = 1'b0;
    end

    // Holding register, FSM state and overrun flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= EMPTY;
            p_out_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_out_q   <= p_out_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.p_out   = p_out_q;
    assign bus.p_valid = (state_q == FULL);
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_sipo_deframer.sv
// Self-checking bench for sipo_deframer: directed scenarios plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_sipo_deframer;
    localparam int unsigned W = 4;

    logic clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    sipo_deframer_if #(.WIDTH(W)) ifc ();

    sipo_deframer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Bits accumulate as acc += s_in * 2^n; a word exists when n reaches W.
    int         m_n    = 0;
    logic [W-1:0] m_acc  = '0;
    logic       m_valid  = 1'b0;
    logic [W-1:0] m_word = '0;
    logic       m_over   = 1'b0;

    int         mn_n;
    logic [W-1:0] mn_acc;
    logic       mn_valid;
    logic [W-1:0] mn_word;
    logic       mn_over;
    logic       m_done;
    logic [W-1:0] m_w;

    always_comb begin
        mn_n     = m_n;
        mn_acc   = m_acc;
        mn_valid = m_valid;
        mn_word  = m_word;
        mn_over  = m_over;
        m_done   = 1'b0;
        m_w      = '0;
        if (ifc.s_clr) begin
            mn_n   = 0;
            mn_acc = '0;
            mn_over = 1'b0;
        end else if (ifc.s_valid) begin
            mn_acc = m_acc | (W'(ifc.s_in) << m_n);
            if (m_n + 1 == W) begin
                m_done = 1'b1;
                m_w    = mn_acc;
                mn_n   = 0;
                mn_acc = '0;
            end else begin
                mn_n = m_n + 1;
            end
        end
        if (m_valid && ifc.p_ready) mn_valid = 1'b0;
        if (m_done) begin
            if (!mn_valid) begin
                mn_valid = 1'b1;
                mn_word  = m_w;
            end else begin
                mn_over = 1'b1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n     <= 0;
            m_acc   <= '0;
            m_valid <= 1'b0;
            m_word  <= '0;
            m_over  <= 1'b0;
        end else begin
            m_n     <= mn_n;
            m_acc   <= mn_acc;
            m_valid <= mn_valid;
            m_word  <= mn_word;
            m_over  <= mn_over;
        end
    end

    // ---------------- checking ----------------
    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_p_valid", 32'(ifc.p_valid), 32'(m_valid));
        check("model_p_out",   32'(ifc.p_out),   32'(m_word));
        check("model_overrun", 32'(ifc.overrun), 32'(m_over));
    end

    // Words actually taken by the consumer.
    logic [W-1:0] got[$];
    always @(negedge clk) begin
        if (rst_n && ifc.p_valid && ifc.p_ready) got.push_back(ifc.p_out);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic rdy);
        ifc.s_valid = 1'b1;
        ifc.s_in    = b;
        ifc.s_clr   = 1'b0;
        ifc.p_ready = rdy;
        tick();
    endtask

    task automatic idle(input logic rdy);
        ifc.s_valid = 1'b0;
        ifc.s_in    = 1'b0;
        ifc.s_clr   = 1'b0;
        ifc.p_ready = rdy;
        tick();
    endtask

    // Sends value LSB first.
    task automatic send_word(input logic [W-1:0] v, input logic rdy);
        for (int i = 0; i < int'(W); i++) send_bit(v[i], rdy);
    endtask

    task automatic pulse_clr(input logic sv);
        ifc.s_valid = sv;
        ifc.s_in    = 1'b1;
        ifc.s_clr   = 1'b1;
        ifc.p_ready = 1'b1;
        tick();
        ifc.s_clr   = 1'b0;
    endtask

    // ---------------- directed + random ----------------
    initial begin
        rst_n       = 1'b0;
        ifc.s_in    = 1'b0;
        ifc.s_valid = 1'b0;
        ifc.s_clr   = 1'b0;
        ifc.p_ready = 1'b0;
        #1;
        check("reset_p_out",   32'(ifc.p_out),   32'h0);
        check("reset_p_valid", 32'(ifc.p_valid), 32'h0);
        check("reset_overrun", 32'(ifc.overrun), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic word: bits 1,0,1,1 -> 4'b1101.
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        check("basic_not_yet", 32'(ifc.p_valid), 32'h0);
        send_bit(1'b1, 1'b1);
        check("basic_p_valid", 32'(ifc.p_valid), 32'h1);
        check("basic_p_out",   32'(ifc.p_out),   32'hD);
        idle(1'b1);
        check("basic_one_cycle", 32'(ifc.p_valid), 32'h0);
        check("basic_overrun",   32'(ifc.overrun), 32'h0);

        // Stall then overrun.
        send_word(4'hD, 1'b0);
        send_word(4'hC, 1'b0);
        check("stall_p_out",   32'(ifc.p_out),   32'hD);
        check("stall_overrun", 32'(ifc.overrun), 32'h1);
        check("stall_p_valid", 32'(ifc.p_valid), 32'h1);
        idle(1'b1);
        check("stall_drained", 32'(ifc.p_valid), 32'h0);
        check("stall_sticky",  32'(ifc.overrun), 32'h1);
        pulse_clr(1'b0);
        check("clr_overrun",   32'(ifc.overrun), 32'h0);

        // Simultaneous drain and fill: A then 5, ready rises on 5's last bit.
        got.delete();
        send_word(4'hA, 1'b0);
        for (int i = 0; i < int'(W) - 1; i++) send_bit(W'(4'h5) >> i, 1'b0);
        send_bit(1'b0, 1'b1);
        check("fill_p_out",    32'(ifc.p_out),   32'h5);
        check("fill_p_valid",  32'(ifc.p_valid), 32'h1);
        idle(1'b1);
        idle(1'b0);
        check("fill_count",    32'(got.size()),  32'h2);
        if (got.size() == 2) begin
            check("fill_first",  32'(got[0]), 32'hA);
            check("fill_second", 32'(got[1]), 32'h5);
        end
        check("fill_overrun",  32'(ifc.overrun), 32'h0);

        // Gapped input.
        for (int i = 0; i < int'(W); i++) begin
            send_bit(W'(4'hD) >> i, 1'b1);
            if (i == int'(W) - 2) check("gap_not_yet", 32'(ifc.p_valid), 32'h0);
            if (i != int'(W) - 1) idle(1'b1);
        end
        check("gap_p_out",   32'(ifc.p_out),   32'hD);
        check("gap_p_valid", 32'(ifc.p_valid), 32'h1);
        idle(1'b1);

        // Realign: two stray bits, clear with a bit present, then 0110.
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        pulse_clr(1'b1);
        send_word(4'h6, 1'b1);
        check("realign_p_out",   32'(ifc.p_out),   32'h6);
        check("realign_p_valid", 32'(ifc.p_valid), 32'h1);
        idle(1'b1);

        // Async reset mid-word with a held word.
        send_word(4'h3, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("pre_reset_valid", 32'(ifc.p_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_p_out",   32'(ifc.p_out),   32'h0);
        check("async_p_valid", 32'(ifc.p_valid), 32'h0);
        check("async_overrun", 32'(ifc.overrun), 32'h0);
        tick();
        rst_n = 1'b1;
        idle(1'b0);
        send_word(4'h9, 1'b1);
        check("post_reset_p_out", 32'(ifc.p_out),   32'h9);
        check("post_reset_valid", 32'(ifc.p_valid), 32'h1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            ifc.s_valid = ($urandom_range(0, 9) < 7);
            ifc.s_in    = $urandom_range(0, 1) == 1;
            ifc.p_ready = ($urandom_range(0, 9) < 4);
            ifc.s_clr   = ($urandom_range(0, 99) < 3);
            tick();
        end
        idle(1'b1);
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
